// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_ctrl
//  Description : Hazard and forwarding controller that sits beside the ID
//                stage and produces the EXE operand selects and freeze.
//                It keeps shadow copies of the EXE, MEM and WB slots, detects
//                RAW and load-use hazards, inserts bubbles and flushes, and
//                holds the whole pipeline while the SRAM data path is not
//                ready.
//
//  Optional feature macro : FORWARDING_EN
//      defined   - operand forwarding from the MEM and WB slots; only a
//                  load-use pair stalls, for exactly one cycle.
//      undefined - o_sel_src1/o_sel_src2 tied to 0; any EXE- or MEM-slot
//                  producer match stalls until the producer reaches WB.
//
//  Ports
//      clk              in   1       pipeline clock, rising edge
//      rst_n            in   1       asynchronous active-low reset
//      i_id_valid       in   1       ID holds a real instruction
//      i_id_src1        in   REG_AW  Rn of the ID instruction
//      i_id_src2        in   REG_AW  Rm (or Rd for a store)
//      i_id_use_src1    in   1       ID instruction reads src1
//      i_id_use_src2    in   1       ID instruction reads src2
//      i_id_dest        in   REG_AW  destination register
//      i_id_wb_en       in   1       ID instruction writes back
//      i_id_mem_r_en    in   1       ID instruction is a load
//      i_id_mem_w_en    in   1       ID instruction is a store
//      i_branch_taken   in   1       EXE resolved a taken branch
//      i_mem_ready      in   1       SRAM finished the MEM-slot access
//      o_sel_src1       out  2       0=val_Rn, 1=alu_result, 2=wb_result
//      o_sel_src2       out  2       same encoding for src2
//      o_hazard_stall   out  1       hold PC and IF/ID, bubble into EXE
//      o_flush          out  1       kill IF/ID contents
//      o_freeze         out  1       hold every pipeline register
//      o_mem_timeout    out  1       sticky: freeze lasted MEM_TIMEOUT cycles
//
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_src1,
    input  logic [REG_AW-1:0] i_id_src2,
    input  logic              i_id_use_src1,
    input  logic              i_id_use_src2,
    input  logic [REG_AW-1:0] i_id_dest,
    input  logic              i_id_wb_en,
    input  logic              i_id_mem_r_en,
    input  logic              i_id_mem_w_en,
    input  logic              i_branch_taken,
    input  logic              i_mem_ready,
    output logic [1:0]        o_sel_src1,
    output logic [1:0]        o_sel_src2,
    output logic              o_hazard_stall,
    output logic              o_flush,
    output logic              o_freeze,
    output logic              o_mem_timeout
);

    localparam int               c_CNT_W   = 8;
    localparam logic [c_CNT_W:0] c_TMO     = MEM_TIMEOUT[c_CNT_W:0];
    localparam logic [1:0]       c_SEL_REG = 2'd0;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Shadow slots
    // ------------------------------------------------------------------
    logic              r_exe_v;
    logic [REG_AW-1:0] r_exe_dest;
    logic              r_exe_wb;
    logic              r_exe_ld;
    logic              r_exe_st;

    logic              r_mem_v;
    logic [REG_AW-1:0] r_mem_dest;
    logic              r_mem_wb;
    logic              r_mem_mem;

    logic              r_wb_v;
    logic [REG_AW-1:0] r_wb_dest;
    logic              r_wb_wb;

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_mem_timeout;

    logic w_exe_m1;
    logic w_exe_m2;
    logic w_mem_m1;
    logic w_mem_m2;
    logic w_hazard;
    logic w_freeze;
    logic w_stall;
    logic w_flush;
    logic w_take;
    logic [c_CNT_W:0] w_cnt_inc;

    // ------------------------------------------------------------------
    // Producer matches against the instruction currently in ID
    // ------------------------------------------------------------------
    assign w_exe_m1 = r_exe_v & r_exe_wb & i_id_use_src1 & (r_exe_dest == i_id_src1);
    assign w_exe_m2 = r_exe_v & r_exe_wb & i_id_use_src2 & (r_exe_dest == i_id_src2);
    assign w_mem_m1 = r_mem_v & r_mem_wb & i_id_use_src1 & (r_mem_dest == i_id_src1);
    assign w_mem_m2 = r_mem_v & r_mem_wb & i_id_use_src2 & (r_mem_dest == i_id_src2);

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded: its data exists after MEM.
    assign w_hazard = i_id_valid & r_exe_ld & (w_exe_m1 | w_exe_m2);
`else
    // Without bypass paths the consumer waits until the producer is in WB,
    // where the register file writes before it is read.
    assign w_hazard = i_id_valid & (w_exe_m1 | w_exe_m2 | w_mem_m1 | w_mem_m2);
`endif

    // ------------------------------------------------------------------
    // FSM next state and same-cycle control outputs
    // ------------------------------------------------------------------
    always_comb begin : p_fsm_comb
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        w_stall     = 1'b0;
        w_flush     = 1'b0;

        // Freeze must act in the very cycle the access is incomplete, so it
        // comes straight from the MEM slot rather than from the state.
        w_freeze = r_mem_v & r_mem_mem & ~i_mem_ready;

        case (r_state)
            ST_RUN:      if (w_freeze)    w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (i_mem_ready) w_state_nxt = ST_RUN;
            default:                      w_state_nxt = ST_RUN;
        endcase

        // A taken branch kills the ID instruction, so a stall on it would
        // be pointless: flush takes precedence.
        if (!w_freeze) begin
            w_flush = i_branch_taken;
            w_stall = ~i_branch_taken & w_hazard;
        end
    end

    // ID instruction moves into EXE this edge (only meaningful when not frozen)
    assign w_take = i_id_valid & ~w_stall & ~i_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin : p_fsm_reg
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Slot advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : p_slots
        if (!rst_n) begin
            r_exe_v    <= 1'b0;
            r_exe_dest <= '0;
            r_exe_wb   <= 1'b0;
            r_exe_ld   <= 1'b0;
            r_exe_st   <= 1'b0;
            r_mem_v    <= 1'b0;
            r_mem_dest <= '0;
            r_mem_wb   <= 1'b0;
            r_mem_mem  <= 1'b0;
            r_wb_v     <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_wb    <= 1'b0;
        end else if (!w_freeze) begin
            if (w_take) begin
                r_exe_v    <= 1'b1;
                r_exe_dest <= i_id_dest;
                r_exe_wb   <= i_id_wb_en;
                r_exe_ld   <= i_id_mem_r_en;
                r_exe_st   <= i_id_mem_w_en;
            end else begin
                r_exe_v    <= 1'b0;
                r_exe_dest <= '0;
                r_exe_wb   <= 1'b0;
                r_exe_ld   <= 1'b0;
                r_exe_st   <= 1'b0;
            end
            r_mem_v    <= r_exe_v;
            r_mem_dest <= r_exe_dest;
            r_mem_wb   <= r_exe_wb;
            r_mem_mem  <= r_exe_ld | r_exe_st;
            r_wb_v     <= r_mem_v;
            r_wb_dest  <= r_mem_dest;
            r_wb_wb    <= r_mem_wb;
        end
    end

    // The WB slot never feeds a select: a WB-slot producer is satisfied by
    // the register file write-before-read. It is tracked for completeness of
    // the pipeline image only.
    logic w_unused_wb;
    assign w_unused_wb = ^{r_wb_v, r_wb_dest, r_wb_wb};

    // ------------------------------------------------------------------
    // Operand selects, latched on the ID->EXE transfer
    // ------------------------------------------------------------------
`ifdef FORWARDING_EN
    localparam logic [1:0] c_SEL_ALU = 2'd1;
    localparam logic [1:0] c_SEL_WB  = 2'd2;

    logic [1:0] r_sel_src1;
    logic [1:0] r_sel_src2;
    logic [1:0] w_sel1_nxt;
    logic [1:0] w_sel2_nxt;

    // Newest producer wins: the EXE-slot instruction will sit in MEM when
    // the consumer executes, the MEM-slot one will sit in WB.
    assign w_sel1_nxt = w_exe_m1 ? c_SEL_ALU : (w_mem_m1 ? c_SEL_WB : c_SEL_REG);
    assign w_sel2_nxt = w_exe_m2 ? c_SEL_ALU : (w_mem_m2 ? c_SEL_WB : c_SEL_REG);

    always_ff @(posedge clk or negedge rst_n) begin : p_sel
        if (!rst_n) begin
            r_sel_src1 <= c_SEL_REG;
            r_sel_src2 <= c_SEL_REG;
        end else if (!w_freeze) begin
            r_sel_src1 <= w_take ? w_sel1_nxt : c_SEL_REG;
            r_sel_src2 <= w_take ? w_sel2_nxt : c_SEL_REG;
        end
    end

    assign o_sel_src1 = r_sel_src1;
    assign o_sel_src2 = r_sel_src2;
`else
    assign o_sel_src1 = c_SEL_REG;
    assign o_sel_src2 = c_SEL_REG;
`endif

    // ------------------------------------------------------------------
    // Freeze watchdog: counts consecutive freeze cycles, saturating
    // ------------------------------------------------------------------
    assign w_cnt_inc = {1'b0, r_tmo_cnt} + {{c_CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin : p_timeout
        if (!rst_n) begin
            r_tmo_cnt     <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_freeze) begin
            if (!w_cnt_inc[c_CNT_W]) begin
                r_tmo_cnt <= w_cnt_inc[c_CNT_W-1:0];
            end
            // w_cnt_inc is the number of freeze cycles including this one
            if (w_cnt_inc >= c_TMO) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            // Back in RUN: the next stall episode is timed from zero
            r_tmo_cnt <= '0;
        end
    end

    assign o_hazard_stall = w_stall;
    assign o_flush        = w_flush;
    assign o_freeze       = w_freeze;
    assign o_mem_timeout  = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
module tb_hazard_forward_ctrl;

    localparam int TMO = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_use_src1;
    logic       id_use_src2;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic       id_mem_w_en;
    logic       branch_taken;
    logic       mem_ready;
    logic [1:0] sel_src1;
    logic [1:0] sel_src2;
    logic       hazard_stall;
    logic       flush;
    logic       freeze;
    logic       mem_timeout;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .REG_AW      (4),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_valid     (id_valid),
        .i_id_src1      (id_src1),
        .i_id_src2      (id_src2),
        .i_id_use_src1  (id_use_src1),
        .i_id_use_src2  (id_use_src2),
        .i_id_dest      (id_dest),
        .i_id_wb_en     (id_wb_en),
        .i_id_mem_r_en  (id_mem_r_en),
        .i_id_mem_w_en  (id_mem_w_en),
        .i_branch_taken (branch_taken),
        .i_mem_ready    (mem_ready),
        .o_sel_src1     (sel_src1),
        .o_sel_src2     (sel_src2),
        .o_hazard_stall (hazard_stall),
        .o_flush        (flush),
        .o_freeze       (freeze),
        .o_mem_timeout  (mem_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: instruction records in pipeline order,
    // index 0 = EXE, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic       v;
        logic [3:0] dest;
        logic       wb;
        logic       ld;
        logic       mem;
    } slot_t;

    slot_t      pipe [3];
    logic [1:0] m_sel1;
    logic [1:0] m_sel2;
    int         m_run;
    logic       m_to;

    // values seen in the cycle just stepped
    logic c_stall;
    logic c_flush;
    logic c_freeze;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Age of the youngest writer of src still in flight (0=EXE, 1=MEM), -1 if none
    function automatic int age_of(input logic [3:0] src, input logic used);
        if (!used) return -1;
        for (int k = 0; k < 2; k++)
            if (pipe[k].v && pipe[k].wb && pipe[k].dest == src) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_sel1 = 2'd0;
        m_sel2 = 2'd0;
        m_run  = 0;
        m_to   = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic [3:0] d,
                          input logic wb, input logic ld, input logic st);
        id_valid    = v;
        id_src1     = s1;
        id_use_src1 = u1;
        id_src2     = s2;
        id_use_src2 = u2;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_mem_w_en = st;
    endtask

    task automatic nop();
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: check against the model at the negedge, then advance the model.
    task automatic step();
        int   a1;
        int   a2;
        logic e_fz;
        logic e_st;
        logic e_fl;
        logic hz;
        logic take;
        @(negedge clk);
        a1   = age_of(id_src1, id_use_src1);
        a2   = age_of(id_src2, id_use_src2);
        e_fz = pipe[1].v && pipe[1].mem && !mem_ready;
`ifdef FORWARDING_EN
        hz = id_valid && pipe[0].ld && (a1 == 0 || a2 == 0);
`else
        hz = id_valid && (a1 >= 0 || a2 >= 0);
`endif
        e_fl = !e_fz && branch_taken;
        e_st = !e_fz && !branch_taken && hz;
        take = id_valid && !e_st && !branch_taken;
        chk("freeze", freeze, e_fz);
        chk("hazard_stall", hazard_stall, e_st);
        chk("flush", flush, e_fl);
        chk("sel_src1", sel_src1, m_sel1);
        chk("sel_src2", sel_src2, m_sel2);
        chk("mem_timeout", mem_timeout, m_to);
        c_stall  = hazard_stall;
        c_flush  = flush;
        c_freeze = freeze;
        @(posedge clk);
        #1;
        if (!e_fz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '0;
            if (take) begin
                pipe[0].v    = 1'b1;
                pipe[0].dest = id_dest;
                pipe[0].wb   = id_wb_en;
                pipe[0].ld   = id_mem_r_en;
                pipe[0].mem  = id_mem_r_en | id_mem_w_en;
            end
`ifdef FORWARDING_EN
            m_sel1 = (take && a1 >= 0) ? 2'(a1 + 1) : 2'd0;
            m_sel2 = (take && a2 >= 0) ? 2'(a2 + 1) : 2'd0;
`endif
            m_run = 0;
        end else begin
            m_run++;
            if (m_run >= TMO) m_to = 1'b1;
        end
    endtask

    // Reset asserted between edges must take effect immediately
    task automatic do_reset();
        nop();
        branch_taken = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst freeze", freeze, 1'b0);
        chk("rst stall", hazard_stall, 1'b0);
        chk("rst flush", flush, 1'b0);
        chk("rst sel_src1", sel_src1, 2'd0);
        chk("rst sel_src2", sel_src2, 2'd0);
        chk("rst mem_timeout", mem_timeout, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
    endtask

    task automatic drain();
        nop();
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        repeat (3) step();
    endtask

    task automatic rand_id();
        int k;
        k = $urandom_range(0, 4);
        if (k == 4) begin
            nop();
        end else begin
            id_valid    = 1'b1;
            id_src1     = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            id_dest     = 4'($urandom_range(0, 3));
            id_use_src1 = 1'($urandom_range(0, 1));
            id_use_src2 = 1'($urandom_range(0, 1));
            id_wb_en    = (k != 3);
            id_mem_r_en = (k == 2);
            id_mem_w_en = (k == 3);
            if (k == 3) id_use_src2 = 1'b1;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        nop();
        model_reset();
        #1;
        do_reset();

        // --- ADD R1 ; SUB R2,R1,R3 ---------------------------------------
        set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0); step();
        set_id(1, 4'd1, 1, 4'd3, 1, 4'd2, 1, 0, 0); step();
`ifdef FORWARDING_EN
        chk("A no stall", c_stall, 1'b0);
        chk("A sel1", sel_src1, 2'd1);
        chk("A sel2", sel_src2, 2'd0);
`else
        chk("A stall1", c_stall, 1'b1);
        step();
        chk("A stall2", c_stall, 1'b1);
        step();
        chk("A enter", c_stall, 1'b0);
        chk("A sel1", sel_src1, 2'd0);
`endif
        drain();

        // --- ADD R1 ; NOP ; ORR R4,R0,R1 ----------------------------------
        set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0); step();
        nop(); step();
        set_id(1, 4'd0, 1, 4'd1, 1, 4'd4, 1, 0, 0); step();
`ifdef FORWARDING_EN
        chk("B no stall", c_stall, 1'b0);
        chk("B sel2", sel_src2, 2'd2);
        chk("B sel1", sel_src1, 2'd0);
`else
        chk("B stall", c_stall, 1'b1);
        step();
        chk("B enter", c_stall, 1'b0);
        chk("B sel2", sel_src2, 2'd0);
`endif
        drain();
        // producer only in WB: register file path
        set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0); step();
        nop(); step(); step();
        set_id(1, 4'd0, 1, 4'd1, 1, 4'd4, 1, 0, 0); step();
        chk("B2 no stall", c_stall, 1'b0);
        chk("B2 sel2", sel_src2, 2'd0);
        drain();

        // --- LDR R5 ; ADD R6,R5,R5 ----------------------------------------
        set_id(1, 4'd0, 1, 4'd0, 0, 4'd5, 1, 1, 0); step();
        set_id(1, 4'd5, 1, 4'd5, 1, 4'd6, 1, 0, 0); step();
        chk("C stall1", c_stall, 1'b1);
        chk("C bubble sel1", sel_src1, 2'd0);
        step();
`ifdef FORWARDING_EN
        chk("C enter", c_stall, 1'b0);
        chk("C sel1", sel_src1, 2'd2);
        chk("C sel2", sel_src2, 2'd2);
`else
        chk("C stall2", c_stall, 1'b1);
        step();
        chk("C enter", c_stall, 1'b0);
        chk("C sel1", sel_src1, 2'd0);
`endif
        drain();

        // --- load held in MEM for 3 cycles -------------------------------
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 1, 0); step();
        nop(); step();
        set_id(1, 4'd7, 1, 4'd0, 0, 4'd8, 1, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            step();
            chk("D freeze", c_freeze, 1'b1);
            chk("D stall forced 0", c_stall, 1'b0);
            chk("D flush forced 0", c_flush, 1'b0);
        end
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        step();
        chk("D resume", c_freeze, 1'b0);
`ifdef FORWARDING_EN
        chk("D sel1", sel_src1, 2'd2);
`else
        chk("D stall after", c_stall, 1'b1);
`endif
        drain();

        // --- branch coincident with load-use -----------------------------
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0); step();
        set_id(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
        branch_taken = 1'b1;
        step();
        chk("F flush", c_flush, 1'b1);
        chk("F stall", c_stall, 1'b0);
        branch_taken = 1'b0;
        set_id(1, 4'd6, 1, 4'd0, 0, 4'd2, 1, 0, 0);
        step();
        chk("F bubble no stall", c_stall, 1'b0);
        chk("F bubble sel1", sel_src1, 2'd0);
        drain();

        // --- freeze watchdog ---------------------------------------------
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 1, 0); step();
        nop(); step();
        mem_ready = 1'b0;
        repeat (TMO - 1) step();
        chk("E timeout before", mem_timeout, 1'b0);
        step();
        chk("E timeout at", mem_timeout, 1'b1);
        mem_ready = 1'b1;
        step(); step();
        chk("E timeout sticky", mem_timeout, 1'b1);
        drain();

        // --- reset in the middle of a freeze -----------------------------
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0); step();
        nop(); step();
        mem_ready = 1'b0;
        step();
        chk("G frozen", c_freeze, 1'b1);
        do_reset();

        // --- randomized traffic against the model ------------------------
        rand_id();
        for (int n = 0; n < 800; n++) begin
            branch_taken = ($urandom_range(0, 9) == 0);
            mem_ready    = ($urandom_range(0, 3) != 0);
            step();
            // a stalled or frozen ID keeps presenting the same instruction
            if (!(c_stall || c_freeze)) rand_id();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
